// File: rtl/ariane_pkg.sv
// Shared address widths and translation-unit handshake types, plus the
// state encoding of the TLB request arbiter.
package ariane_pkg;

  localparam int unsigned VLEN = 64;
  localparam int unsigned PLEN = 56;

  // Request leg toward the translation unit.
  typedef struct packed {
    logic            fetch_req;
    logic [VLEN-1:0] fetch_vaddr;
  } icache_arsp_t;

  // Reply leg from the translation unit.
  typedef struct packed {
    logic            fetch_valid;
    logic [PLEN-1:0] fetch_paddr;
  } icache_areq_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XLATE = 2'd1,
    RESP  = 2'd2
  } tlb_arb_state_e;

endpackage

// File: rtl/tlb_rr_arb.sv
// Round-robin picker: starting at ptr_i, the first requesting index wins.
// Pure combinational; the caller owns the pointer register.
module tlb_rr_arb #(
  parameter int NR_REQ = 2,
  parameter int IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic [NR_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NR_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  localparam logic [IDX_W:0] NR = (IDX_W + 1)'(NR_REQ);

  logic [IDX_W:0] pos;
  logic           found;

  // ptr + i never reaches 2*NR_REQ, so one conditional subtract wraps it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      pos = {1'b0, ptr_i} + (IDX_W + 1)'(i);
      if (pos >= NR) pos = pos - NR;
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found                   = 1'b1;
        gnt_o[pos[IDX_W-1:0]]   = 1'b1;
        idx_o                   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tlb_arb.sv
// Shares one translation unit among NR_REQ requesters; a single translation
// is in flight at a time and requesters are served round-robin.
module tlb_arb
  import ariane_pkg::*;
#(
  parameter int NR_REQ = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NR_REQ-1:0]            req_valid_i,
  output logic [NR_REQ-1:0]            req_ready_o,
  input  logic [NR_REQ-1:0][VLEN-1:0]  req_vaddr_i,
  output logic [NR_REQ-1:0]            rsp_valid_o,
  input  logic [NR_REQ-1:0]            rsp_ready_i,
  output logic [PLEN-1:0]              rsp_paddr_o,
  output icache_arsp_t                 tlb_req_o,
  input  icache_areq_t                 tlb_rsp_i
);

  localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  tlb_arb_state_e   state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VLEN-1:0]  vaddr_q, vaddr_d;
  logic [PLEN-1:0]  paddr_q, paddr_d;

  logic [NR_REQ-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              rsp_ack;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) >= NR_REQ - 1) return '0;
    else return i + IDX_W'(1);
  endfunction

  tlb_rr_arb #(
    .NR_REQ (NR_REQ),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Only the granted requester may complete the response handshake.
  assign rsp_ack = rsp_ready_i[idx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vaddr_d = vaddr_q;
    paddr_d = paddr_q;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          idx_d   = gnt_idx;
          vaddr_d = req_vaddr_i[gnt_idx];
          ptr_d   = wrap_inc(gnt_idx);
          state_d = XLATE;
        end
      end
      XLATE: begin
        if (tlb_rsp_i.fetch_valid) begin
          paddr_d = tlb_rsp_i.fetch_paddr;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      vaddr_q <= '0;
      paddr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vaddr_q <= vaddr_d;
      paddr_q <= paddr_d;
    end
  end

  // Ready is gated by rst_ni so a pending request is not acknowledged while
  // the block is held in reset.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && rst_ni) req_ready_o = gnt;
  end

  always_comb begin
    tlb_req_o = '0;
    if (state_q == XLATE) begin
      tlb_req_o.fetch_req   = 1'b1;
      tlb_req_o.fetch_vaddr = vaddr_q;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_paddr_o = '0;
    if (state_q == RESP) begin
      rsp_valid_o[idx_q] = 1'b1;
      rsp_paddr_o        = paddr_q;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_rsp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));
  a_paddr_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o == '0) |-> (rsp_paddr_o == '0));
`endif

endmodule

// File: doc/tlb_arb.md
TLB_ARB -- requirements
Module: tlb_arb

Interface
REQ-001 SHALL have parameter NR_REQ, default 2, number of translation requesters (2..4).
REQ-002 SHALL have clk_i  input  1  single clock, rising edge.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i  input  NR_REQ  per-requester translation request.
REQ-005 SHALL have req_ready_o  output  NR_REQ  per-requester accept; one-hot or zero.
REQ-006 SHALL have req_vaddr_i  input  NR_REQ x VLEN  per-requester virtual address.
REQ-007 SHALL have rsp_valid_o  output  NR_REQ  per-requester response valid; one-hot or zero.
REQ-008 SHALL have rsp_ready_i  input  NR_REQ  per-requester response accept.
REQ-009 SHALL have rsp_paddr_o  output  PLEN  translated physical address, shared by all requesters.
REQ-010 SHALL have tlb_req_o  output  icache_arsp_t  request to translation unit (fetch_req, fetch_vaddr).
REQ-011 SHALL have tlb_rsp_i  input  icache_areq_t  reply from translation unit (fetch_valid, fetch_paddr).

Function
REQ-012 SHALL implement FSM states IDLE, XLATE, RESP; only one translation outstanding.
REQ-013 IDLE: if any req_valid_i, SHALL grant one requester round-robin, assert its req_ready_o for that cycle, capture its vaddr and index, go XLATE.
REQ-014 req_ready_o SHALL be 0 in XLATE and RESP; it SHALL NOT depend combinationally on rsp_ready_i.
REQ-015 Round-robin: priority pointer SHALL move to (granted index + 1) mod NR_REQ on each grant; the lowest index wins from reset.
REQ-016 XLATE: SHALL drive tlb_req_o.fetch_req=1 with the captured vaddr; on fetch_valid=1, capture fetch_paddr and go RESP; on fetch_valid=0, hold request and stay XLATE.
REQ-017 tlb_req_o.fetch_req and fetch_vaddr SHALL be 0 outside XLATE.
REQ-018 RESP: SHALL assert rsp_valid_o[granted] with rsp_paddr_o stable until rsp_ready_i[granted]=1, then go IDLE.
REQ-019 Best-case latency: accept at cycle N, tlb request at N+1, rsp_valid_o at N+2; next grant no earlier than the cycle after the response handshake.
REQ-020 rsp_ready_i of non-granted requesters SHALL be ignored; a requester dropping req_valid_i after acceptance SHALL NOT cancel the translation.
REQ-021 Simultaneous requests from all requesters SHALL each be served exactly once per NR_REQ grants (no starvation).
REQ-022 rsp_paddr_o SHALL be 0 whenever no rsp_valid_o bit is set.

Reset
REQ-023 On rst_ni=0, SHALL asynchronously enter IDLE, clear priority pointer to 0, and clear captured vaddr, paddr and index.
REQ-024 During reset all outputs SHALL be 0; an in-flight translation SHALL be discarded with no response issued after release.
REQ-025 After reset release, first grant SHALL occur no earlier than the first rising edge with rst_ni=1.

Structure
REQ-026 VLEN, PLEN, icache_arsp_t and icache_areq_t SHALL come from ariane_pkg; an FSM state enum tlb_arb_state_e SHALL be added there.
REQ-027 Round-robin selection SHALL be a sub-module tlb_rr_arb (inputs request vector and pointer, outputs one-hot grant and index).
REQ-028 All state SHALL be held in flops on clk_i with asynchronous clear on rst_ni; no latches.

Verification
REQ-029 Single request: req0 vaddr 0x1000, translation model returns vaddr+0xF -> req_ready_o=01 at cycle 0, fetch_req at 1, rsp_valid_o=01, paddr 0x100F at 2.
REQ-030 Contention: req0 and req1 continuously valid from reset -> grant order 0,1,0,1; responses 0x100F, 0x200F for vaddrs 0x1000, 0x2000.
REQ-031 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and paddr held stable, no new req_ready_o, completion on cycle rsp_ready_i rises.
REQ-032 Stalled translation: fetch_valid=0 for 3 cycles -> fetch_req held with same vaddr, response 3 cycles late, paddr correct.
REQ-033 Reset mid-XLATE: rst_ni low one cycle -> all outputs 0 immediately, no stale rsp_valid_o after release; next grant goes to req0.
REQ-034 Wrong rsp_ready: rsp_ready_i=10 while serving req0 -> FSM stays RESP until rsp_ready_i[0]=1.
